// File: rtl/prog_counter_reg_if.sv
// Request/status bundle for the programmable up/down counter.
// The master side drives requests and operands; the slave side
// (the counter) returns the count and its status flags.
interface prog_counter_reg_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             ld;
    logic             inc;
    logic             dec;
    logic             clr_flags;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             at_max;
    logic             ovf;
    logic             unf;
    logic             err;

    modport master (
        output en, ld, inc, dec, clr_flags, in, step,
        input  out, zero, at_max, ovf, unf, err
    );

    modport slave (
        input  en, ld, inc, dec, clr_flags, in, step,
        output out, zero, at_max, ovf, unf, err
    );
endinterface

// File: rtl/prog_counter_reg.sv
// Programmable up/down counter with range 0..MAX, wrap or saturate on
// overflow/underflow, one-cycle ovf/unf pulses and a sticky err flag.
module prog_counter_reg #(
    parameter int WIDTH = 6,
    parameter int MAX   = 63,
    parameter bit SAT   = 1'b0
) (
    input logic              clk,
    input logic              rst,
    prog_counter_reg_if.slave bus
);

    // Extended-width constants: one spare bit keeps out+s free of carry loss.
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   MOD_X = MAX_X + (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             err_q, err_d;

    logic [WIDTH:0] in_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] s_x;
    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] sum_x;

    // Next count and flags: ld beats a lone inc/dec; inc together with dec holds.
    always_comb begin
        in_x   = {1'b0, bus.in};
        step_x = {1'b0, bus.step};
        cnt_x  = {1'b0, cnt_q};
        s_x    = (step_x > MAX_X) ? MAX_X : step_x;
        sum_x  = cnt_x + s_x;

        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;

        if (bus.en) begin
            if (bus.ld) begin
                cnt_d = (in_x > MAX_X) ? MAX_W : bus.in;
            end else if (bus.inc && !bus.dec) begin
                if (sum_x > MAX_X) begin
                    ovf_d = 1'b1;
                    cnt_d = SAT ? MAX_W : WIDTH'(sum_x - MOD_X);
                end else begin
                    cnt_d = sum_x[WIDTH-1:0];
                end
            end else if (bus.dec && !bus.inc) begin
                if (cnt_x >= s_x) begin
                    cnt_d = WIDTH'(cnt_x - s_x);
                end else begin
                    unf_d = 1'b1;
                    cnt_d = SAT ? '0 : WIDTH'(cnt_x + MOD_X - s_x);
                end
            end
        end

        // A new event wins over a simultaneous clear; clear ignores en.
        if (ovf_d || unf_d) begin
            err_d = 1'b1;
        end else if (bus.clr_flags) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            err_q <= err_d;
        end
    end

    assign bus.out    = cnt_q;
    assign bus.zero   = (cnt_q == '0);
    assign bus.at_max = (cnt_q == MAX_W);
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_prog_counter_reg.sv
// Bench for prog_counter_reg: four instances (MAX 63/50 x wrap/saturate)
// share one stimulus; directed scenarios plus a randomized run against
// an integer reference model.
module tb_prog_counter_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en, ld, inc, dec, clr_flags;
    logic [5:0] din, step;

    logic [5:0] o_out   [4];
    logic       o_zero  [4];
    logic       o_atmax [4];
    logic       o_ovf   [4];
    logic       o_unf   [4];
    logic       o_err   [4];

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt [4];
    bit m_ovf [4];
    bit m_unf [4];
    bit m_err [4];

    always #5 clk = ~clk;

    // Instance g: 0 = MAX63 wrap, 1 = MAX50 sat, 2 = MAX50 wrap, 3 = MAX63 sat.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int MAXV = (g == 1 || g == 2) ? 50 : 63;
        localparam bit SATV = (g == 1 || g == 3);

        prog_counter_reg_if #(.WIDTH(6)) bus ();

        assign bus.en        = en;
        assign bus.ld        = ld;
        assign bus.inc       = inc;
        assign bus.dec       = dec;
        assign bus.clr_flags = clr_flags;
        assign bus.in        = din;
        assign bus.step      = step;

        prog_counter_reg #(.WIDTH(6), .MAX(MAXV), .SAT(SATV)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign o_out[g]   = bus.out;
        assign o_zero[g]  = bus.zero;
        assign o_atmax[g] = bus.at_max;
        assign o_ovf[g]   = bus.ovf;
        assign o_unf[g]   = bus.unf;
        assign o_err[g]   = bus.err;
    end

    function automatic int max_of(input int i);
        return (i == 1 || i == 2) ? 50 : 63;
    endfunction

    function automatic bit sat_of(input int i);
        return (i == 1 || i == 3);
    endfunction

    task automatic idle();
        en = 1'b1; ld = 1'b0; inc = 1'b0; dec = 1'b0; clr_flags = 1'b0;
        din = '0; step = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_out[i] !== 6'd0 || o_zero[i] !== 1'b1 || o_atmax[i] !== 1'b0 ||
                o_ovf[i] !== 1'b0 || o_unf[i] !== 1'b0 || o_err[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: out=%0d zero=%b at_max=%b ovf=%b unf=%b err=%b, want 0 1 0 0 0 0",
                         i, o_out[i], o_zero[i], o_atmax[i], o_ovf[i], o_unf[i], o_err[i]);
            end
        end
    endtask

    task automatic test_load_wrap();
        apply_reset();
        ld = 1'b1; din = 6'd45;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd45 || o_ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL load45: out=%0d ovf=%b, want 45 0", o_out[0], o_ovf[0]);
        end
        idle(); inc = 1'b1; step = 6'd20;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd1 || o_ovf[0] !== 1'b1 || o_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL inc_wrap: out=%0d ovf=%b err=%b, want 1 1 1", o_out[0], o_ovf[0], o_err[0]);
        end
        idle();
        tick();
        n_tests++;
        if (o_out[0] !== 6'd1 || o_ovf[0] !== 1'b0 || o_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pulse: out=%0d ovf=%b err=%b, want 1 0 1", o_out[0], o_ovf[0], o_err[0]);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        ld = 1'b1; din = 6'd60;
        tick();
        n_tests++;
        if (o_out[1] !== 6'd50 || o_atmax[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_load: out=%0d at_max=%b, want 50 1", o_out[1], o_atmax[1]);
        end
        idle(); inc = 1'b1; step = 6'd3;
        tick();
        n_tests++;
        if (o_out[1] !== 6'd50 || o_ovf[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_inc: out=%0d ovf=%b, want 50 1", o_out[1], o_ovf[1]);
        end
        idle(); dec = 1'b1; step = 6'd51;
        tick();
        n_tests++;
        if (o_out[1] !== 6'd0 || o_zero[1] !== 1'b1 || o_unf[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_dec_clamp: out=%0d zero=%b unf=%b, want 0 1 0", o_out[1], o_zero[1], o_unf[1]);
        end
    endtask

    task automatic test_underflow_clr();
        apply_reset();
        ld = 1'b1; din = 6'd2;
        tick();
        idle(); dec = 1'b1; step = 6'd5;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd61 || o_unf[0] !== 1'b1 || o_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_wrap: out=%0d unf=%b err=%b, want 61 1 1", o_out[0], o_unf[0], o_err[0]);
        end
        idle(); clr_flags = 1'b1; inc = 1'b1; step = 6'd10;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd7 || o_ovf[0] !== 1'b1 || o_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_event: out=%0d ovf=%b err=%b, want 7 1 1", o_out[0], o_ovf[0], o_err[0]);
        end
        idle(); clr_flags = 1'b1;
        tick();
        n_tests++;
        if (o_err[0] !== 1'b0 || o_ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_clr: err=%b ovf=%b, want 0 0", o_err[0], o_ovf[0]);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        ld = 1'b1; inc = 1'b1; dec = 1'b1; din = 6'd7; step = 6'd3;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd7 || o_ovf[0] !== 1'b0 || o_unf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_priority: out=%0d ovf=%b unf=%b, want 7 0 0", o_out[0], o_ovf[0], o_unf[0]);
        end
        idle(); inc = 1'b1; dec = 1'b1; step = 6'd60;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd7 || o_ovf[0] !== 1'b0 || o_unf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_dec_hold: out=%0d ovf=%b unf=%b, want 7 0 0", o_out[0], o_ovf[0], o_unf[0]);
        end
        idle(); inc = 1'b1; step = 6'd60;
        tick();
        idle(); en = 1'b0; inc = 1'b1; step = 6'd5;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd3 || o_ovf[0] !== 1'b0 || o_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL en_low_hold: out=%0d ovf=%b err=%b, want 3 0 1", o_out[0], o_ovf[0], o_err[0]);
        end
        idle(); en = 1'b0; clr_flags = 1'b1;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd3 || o_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_clr: out=%0d err=%b, want 3 0", o_out[0], o_err[0]);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ld = 1'b1; din = 6'd30;
        tick();
        idle(); inc = 1'b1; step = 6'd5;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (o_out[0] !== 6'd0 || o_zero[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst: out=%0d zero=%b, want 0 1", o_out[0], o_zero[0]);
        end
        ld = 1'b1; din = 6'd9;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_ignores_req: out=%0d, want 0", o_out[0]);
        end
        #2;
        rst = 1'b0;
        idle(); inc = 1'b1; step = 6'd5;
        tick();
        n_tests++;
        if (o_out[0] !== 6'd5) begin
            n_fail++;
            $display("FAIL first_after_rst: out=%0d, want 5", o_out[0]);
        end
    endtask

    task automatic test_random();
        int c, s, t, mx;
        bit nov, nun;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_err[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            en        = ($urandom_range(0, 7) != 0);
            ld        = ($urandom_range(0, 9) == 0);
            inc       = $urandom_range(0, 1);
            dec       = $urandom_range(0, 1);
            clr_flags = ($urandom_range(0, 7) == 0);
            din       = 6'($urandom_range(0, 63));
            step      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));

            for (int i = 0; i < 4; i++) begin
                mx  = max_of(i);
                c   = m_cnt[i];
                nov = 0;
                nun = 0;
                if (en) begin
                    if (ld) begin
                        c = (int'(din) > mx) ? mx : int'(din);
                    end else if (inc != dec) begin
                        s = (int'(step) > mx) ? mx : int'(step);
                        if (inc) begin
                            t = c + s;
                            if (t > mx) begin
                                nov = 1;
                                c = sat_of(i) ? mx : t - (mx + 1);
                            end else begin
                                c = t;
                            end
                        end else begin
                            t = c - s;
                            if (t < 0) begin
                                nun = 1;
                                c = sat_of(i) ? 0 : t + mx + 1;
                            end else begin
                                c = t;
                            end
                        end
                    end
                end
                m_cnt[i] = c;
                m_ovf[i] = nov;
                m_unf[i] = nun;
                m_err[i] = (nov || nun) ? 1'b1 : (clr_flags ? 1'b0 : m_err[i]);
            end

            tick();

            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (o_out[i] !== 6'(m_cnt[i]) || o_ovf[i] !== m_ovf[i] || o_unf[i] !== m_unf[i] ||
                    o_err[i] !== m_err[i] || o_zero[i] !== (m_cnt[i] == 0) ||
                    o_atmax[i] !== (m_cnt[i] == max_of(i))) begin
                    n_fail++;
                    $display("FAIL random[%0d] cyc %0d: out=%0d ovf=%b unf=%b err=%b zero=%b at_max=%b, want %0d %b %b %b %b %b",
                             i, cyc, o_out[i], o_ovf[i], o_unf[i], o_err[i], o_zero[i], o_atmax[i],
                             m_cnt[i], m_ovf[i], m_unf[i], m_err[i], (m_cnt[i] == 0), (m_cnt[i] == max_of(i)));
                end
            end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        test_reset();
        test_load_wrap();
        test_saturate();
        test_underflow_clr();
        test_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
